gate_selftest_ctrl: RTL
=======================

Name: gate_selftest_ctrl

Overview:
- Sequencer that exhaustively exercises one combinational N-input gate (OR/AND/XOR/... structural, dataflow or behavioural model) in hardware.
- Steps the gate's inputs through every combination and samples its output after a settle delay.
- Compares each sample against a programmable truth table and reports pass/fail, an error count and a per-vector failure mask.
- Sits between a top-level test controller (start/done) and the gate under test (dut_in/dut_y).

Parameters:
- N_IN, 2, number of gate inputs; vector count V = 2**N_IN; legal range 1..4.
- SETTLE, 2, cycles each vector is held before its output is sampled; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a run; sampled only in IDLE.
- expected  input  V  truth table; bit i is the required dut_y for dut_in == i.
- dut_in  output  N_IN  gate inputs; MSB drives the first gate input (a), LSB the last (b).
- dut_y  input  1  gate output.
- busy  output  1  high from the cycle after start is accepted until the DONE cycle, inclusive.
- done  output  1  single-cycle pulse when a run completes.
- pass  output  1  1 when the last completed run had zero mismatches.
- err_count  output  N_IN+1  number of mismatching vectors in the current/last run.
- fail_mask  output  V  bit i set if vector i mismatched.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, dut_in=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, idx=0, settle counter=0.
- Reset mid-run aborts immediately. No done pulse is generated, and the results are cleared as above.
- States:
  - IDLE: start=1 latches expected into an internal register, clears err_count/fail_mask/pass, sets idx=0 and dut_in=0, settle counter=0, then goes to WAIT.
  - WAIT: dut_in=idx is held. The settle counter increments each cycle. After SETTLE cycles in WAIT, go to SAMPLE.
  - SAMPLE: compare dut_y with the latched expected[idx].
    - On mismatch: err_count+1 and fail_mask[idx]=1, both registered at the end of this cycle.
    - If idx==V-1, go to DONE. Otherwise idx+1, dut_in=idx+1, counter=0, then WAIT.
  - DONE: done=1 for this cycle only. pass=(err_count==0 including the final sample), registered so that pass is valid in the DONE cycle. Then go to IDLE.
- Timing: if start is high in cycle 0, vector k is driven during cycles 1+k*(SETTLE+1) .. (k+1)*(SETTLE+1), and it is sampled in the last of those cycles. done is asserted in cycle 1+V*(SETTLE+1), which is cycle 13 for the defaults.
- dut_in changes only on the cycle after a SAMPLE. It holds its last vector (V-1) after the run until the next start.
- start while busy is ignored. Changes to expected during a run have no effect.
- start still high in the cycle after DONE (state IDLE) launches a new run. A held start therefore gives back-to-back runs with one IDLE cycle between them.
- err_count cannot overflow: its width N_IN+1 holds V.
- pass, err_count and fail_mask hold their values after done until the next accepted start.
- Out-of-range parameters are unsupported; the implementation shall not be required to handle them.

Test Plan:
- Correct OR gate, expected=4'b1110, defaults, start pulsed in cycle 0. Required:
  - dut_in = 00,01,10,11, each held 3 cycles.
  - done in cycle 13 only, pass=1, err_count=0, fail_mask=0000.
- AND gate connected, expected=4'b1110 (OR table). Required: done in cycle 13, pass=0, err_count=2, fail_mask=4'b0110.
- dut_y tied 1, expected=4'b0000. Required: err_count=4, fail_mask=4'b1111, pass=0, busy high in cycles 1..13.
- Extra start pulses in cycles 5 and 9, and expected changed to 4'b0000 in cycle 6. Required: these have no effect, and the cycle-13 results match scenario 1.
- rst_n low in cycle 7 of a run. Required:
  - Immediately, all outputs are 0 and dut_in=00.
  - No done pulse follows.
  - A new start after release completes normally 13 cycles later.
- start held high for 30 cycles with a correct OR gate. Required: done in cycles 13 and 27, pass=1 at both, busy low in cycle 14.

Source files
------------

// File: rtl/gate_selftest_ctrl.sv
// gate_selftest_ctrl: exhaustive self-test sequencer for one N_IN-input combinational gate.
// Steps dut_in through every vector. Each vector is held SETTLE cycles, and dut_y is then
// sampled and checked against a truth table latched at start.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a run (only looked at while idle)
//   expected   truth table, bit i = required dut_y for dut_in == i
//   dut_in     gate inputs (MSB = first gate input)
//   dut_y      gate output
//   busy       high from the first WAIT cycle through the DONE cycle
//   done       one-cycle pulse at run completion
//   pass       last completed run had no mismatches
//   err_count  mismatching vectors in current/last run
//   fail_mask  bit i set when vector i mismatched
module gate_selftest_ctrl #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 2,
  localparam int unsigned V     = 1 << N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [V-1:0]    expected,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [V-1:0]    fail_mask
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StWait   = 2'd1;
  localparam logic [1:0] StSample = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [V-1:0]    exp_q, exp_d;
  logic [N_IN:0]   err_q, err_d;
  logic [V-1:0]    mask_q, mask_d;
  logic            pass_q, pass_d;
  logic            mismatch;

  assign mismatch = (dut_y != exp_q[idx_q]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    err_d   = err_q;
    mask_d  = mask_q;
    pass_d  = pass_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          exp_d   = expected;
          err_d   = '0;
          mask_d  = '0;
          pass_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'(SETTLE - 1)) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StSample: begin
        if (mismatch) begin
          err_d         = err_q + (N_IN + 1)'(1);
          mask_d[idx_q] = 1'b1;
        end
        if (idx_q == N_IN'(V - 1)) begin
          // Uses err_d so the final sample counts towards the verdict shown in DONE.
          pass_d  = (err_d == '0);
          state_d = StDone;
        end else begin
          idx_d   = idx_q + N_IN'(1);
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      err_q   <= '0;
      mask_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
    end
  end

  // The vector index doubles as the gate stimulus; it stays at V-1 after a run.
  assign dut_in    = idx_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = mask_q;

endmodule
